// File: rtl/pc_scan_ctrl.sv
// Scan controller for the PC muxed-D scan path: freezes the core and rotates or loads the PC; response valid 19 cycles after accept (ADDR_WIDTH=16).
// Accepts only in IDLE and holds the response until i_rsp_ready; PC_SCAN_READBACK_EN adds the capture register returning the pre-operation PC.
module pc_scan_ctrl #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rstn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ADDR_WIDTH-1:0] o_rsp_data,
  output logic                  o_scan_en,
  output logic                  o_scan_in,
  input  logic                  i_scan_out,
  output logic                  o_core_freeze,
  output logic                  o_busy
);

  localparam int CNT_WIDTH = $clog2(ADDR_WIDTH + 2);
  localparam logic [CNT_WIDTH-1:0] LAST_J = CNT_WIDTH'(ADDR_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FREEZE,
    ST_SHIFT,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  // Latched data shifts left once per shift from j=1 on, so its MSB is always data[ADDR_WIDTH-j].
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          state_d = ST_FREEZE;
          wr_d    = i_req_write;
          data_d  = i_req_data;
        end
      end
      ST_FREEZE: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          data_d = {data_q[ADDR_WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST_J) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PC_SCAN_READBACK_EN
  logic [ADDR_WIDTH-1:0] cap_q, cap_d;

  // Bits arrive MSB first from the scan-out flop, one per shift from j=1.
  always_comb begin
    cap_d = cap_q;
    if (state_q == ST_IDLE && i_req_valid) begin
      cap_d = '0;
    end else if (state_q == ST_SHIFT && cnt_q != '0) begin
      cap_d = {cap_q[ADDR_WIDTH-2:0], i_scan_out};
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign o_rsp_data = cap_q;
`else
  assign o_rsp_data = '0;
`endif

  assign o_req_ready   = (state_q == ST_IDLE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_scan_en     = (state_q == ST_SHIFT);
  assign o_core_freeze = (state_q == ST_FREEZE) || (state_q == ST_SHIFT);
  assign o_rsp_valid   = (state_q == ST_RESP);
  // j=0 always recirculates the scan-out flop; reads keep recirculating for a full ring rotation.
  assign o_scan_in     = (state_q == ST_SHIFT) &&
                         ((wr_q && cnt_q != '0) ? data_q[ADDR_WIDTH-1] : i_scan_out);

endmodule

// File: tb/tb_pc_scan_ctrl.sv
// Directed bench for pc_scan_ctrl driving a behavioural PC scan ring; expectations follow PC_SCAN_READBACK_EN.
module tb_pc_scan_ctrl;

`ifdef PC_SCAN_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        scan_en;
  logic        scan_in;
  logic        scan_out;
  logic        core_freeze;
  logic        busy;

  pc_scan_ctrl #(.ADDR_WIDTH(16)) dut (
    .i_sys_clk    (clk),
    .i_sys_rstn   (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_data   (req_data),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_scan_en    (scan_en),
    .o_scan_in    (scan_in),
    .i_scan_out   (scan_out),
    .o_core_freeze(core_freeze),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PC with its scan-out flop: a 17-stage ring while scan is enabled.
  logic [15:0] pc_q;
  logic        so_q;
  logic        pc_set;
  logic [15:0] pc_set_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 16'h0;
      so_q <= 1'b0;
    end else if (pc_set) begin
      pc_q <= pc_set_val;
    end else if (scan_en) begin
      so_q <= pc_q[15];
      pc_q <= {pc_q[14:0], scan_in};
    end
  end
  assign scan_out = so_q;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rexp(input logic [15:0] v);
    return RB ? v : 16'h0;
  endfunction

  task automatic set_pc(input logic [15:0] v);
    pc_set     = 1'b1;
    pc_set_val = v;
    @(negedge clk);
    pc_set     = 1'b0;
  endtask

  // Called at a negedge while idle; returns at the negedge of the first response cycle.
  task automatic do_req(input logic wr, input logic [15:0] dat, output int lat,
                        output int sen, output logic [15:0] rsp, output int acc_at);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_data  = dat;
    acc_at    = cyc_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_data  = 16'h0;
    @(negedge clk);
    lat = 1;
    sen = 0;
    while (!rsp_valid && lat < 100) begin
      if (scan_en) sen++;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    rsp = rsp_data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready},   32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid},   32'd0);
    check({tag, "_rsp_data"},  {16'd0, rsp_data},    32'd0);
    check({tag, "_scan_en"},   {31'd0, scan_en},     32'd0);
    check({tag, "_scan_in"},   {31'd0, scan_in},     32'd0);
    check({tag, "_freeze"},    {31'd0, core_freeze}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          lat, sen, acc1, acc2;
    logic [15:0] rsp;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_data   = 16'h0;
    rsp_ready  = 1'b1;
    pc_set     = 1'b0;
    pc_set_val = 16'h0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Write 0xBEEF over PC=0.
    do_req(1'b1, 16'hBEEF, lat, sen, rsp, acc1);
    check("wr_latency", lat, 32'd19);
    check("wr_scan_en_cycles", sen, 32'd17);
    check("wr_rsp", {16'd0, rsp}, {16'd0, rexp(16'h0000)});
    check("wr_resp_freeze", {31'd0, core_freeze}, 32'd0);
    check("wr_resp_busy", {31'd0, busy}, 32'd1);
    check("wr_resp_req_ready", {31'd0, req_ready}, 32'd0);
    check("wr_pc", {16'd0, pc_q}, 32'h0000BEEF);
    @(negedge clk);
    check("wr_back_idle", {31'd0, busy}, 32'd0);

    // Non-destructive readback of 0x1234.
    set_pc(16'h1234);
    do_req(1'b0, 16'h0, lat, sen, rsp, acc1);
    check("rd_latency", lat, 32'd19);
    check("rd_rsp", {16'd0, rsp}, {16'd0, rexp(16'h1234)});
    check("rd_pc", {16'd0, pc_q}, 32'h00001234);
    @(negedge clk);

    // Response back-pressure with a second request that must be ignored.
    rsp_ready = 1'b0;
    do_req(1'b1, 16'h5A5A, lat, sen, rsp, acc1);
    check("bp_latency", lat, 32'd19);
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", {16'd0, rsp_data}, {16'd0, rexp(16'h1234)});
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_done_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("bp_no_second_op", {31'd0, busy}, 32'd0);
    check("bp_pc", {16'd0, pc_q}, 32'h00005A5A);

    // Back-to-back: write then read issued the cycle after the response completes.
    do_req(1'b1, 16'hA5A5, lat, sen, rsp, acc1);
    check("b2b_wr_rsp", {16'd0, rsp}, {16'd0, rexp(16'h5A5A)});
    @(negedge clk);
    do_req(1'b0, 16'h0, lat, sen, rsp, acc2);
    check("b2b_spacing", acc2 - acc1, 32'd20);
    check("b2b_rd_rsp", {16'd0, rsp}, {16'd0, rexp(16'hA5A5)});
    check("b2b_pc", {16'd0, pc_q}, 32'h0000A5A5);
    @(negedge clk);

    // Reset pulse at SHIFT j=8.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_data  = 16'hFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_data  = 16'h0;
    repeat (9) @(posedge clk);
    #2;
    check("mid_scan_en", {31'd0, scan_en}, 32'd1);
    check("mid_freeze", {31'd0, core_freeze}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    check("mid_rst_pc", {16'd0, pc_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 16'h0, lat, sen, rsp, acc1);
    check("after_rst_rsp", {16'd0, rsp}, 32'd0);
    check("after_rst_pc", {16'd0, pc_q}, 32'd0);
    @(negedge clk);

    // Write 0x00FF over PC=0x1234.
    set_pc(16'h1234);
    do_req(1'b1, 16'h00FF, lat, sen, rsp, acc1);
    check("ff_latency", lat, 32'd19);
    check("ff_scan_en_cycles", sen, 32'd17);
    check("ff_rsp", {16'd0, rsp}, {16'd0, rexp(16'h1234)});
    check("ff_pc", {16'd0, pc_q}, 32'h000000FF);
    @(negedge clk);
    check("ff_idle", {31'd0, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
